display_scan_ctrl: RTL and testbench

Time-multiplexing controller that shares the single combinational parity-checking `Display` decoder among `DIGITS` physical seven-segment digits. It holds one 5-bit code plus parity bit per digit in a small register file, and presents each entry in turn to `Display`. It captures the decoder's `seg`/`valid` result and drives the digit enables round-robin with a programmable dwell time. It sits between the code source and the `Display` instance, and keeps a sticky per-digit parity-error flag.

---
 rtl/display_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexes one combinational parity-checking seven-segment decoder
// across DIGITS physical digits. Each digit is visited as
// BLANK -> LATCH -> SHOW x DIV. The decoder result is captured in LATCH and
// held while the digit is lit. Parity failures set a sticky per-digit flag.
module display_scan_ctrl #(
  parameter  int DIGITS = 4,
  parameter  int DIV    = 4,
  localparam int AW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [4:0]        wr_E_i,
  input  logic              wr_P_i,
  input  logic              err_clr_i,
  output logic [4:0]        E_o,
  output logic              P_o,
  input  logic [6:0]        seg_in_i,
  input  logic              valid_in_i,
  output logic [6:0]        seg_out_o,
  output logic [DIGITS-1:0] an_o,
  output logic [DIGITS-1:0] err_o
);

  // Dwell counter width; a DIV of 1 still needs one bit.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Register file entry layout: {E[4:0], P}.
  logic [5:0]        mem_q [DIGITS];
  logic [4:0]        E_q;
  logic              P_q;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] err_q, err_d;

  logic              wr_hit;
  logic              last_dwell;
  logic              last_idx;

  assign wr_hit     = wr_en_i && (int'(wr_addr_i) < DIGITS);
  assign last_dwell = (cnt_q == CW'(DIV - 1));
  assign last_idx   = (idx_q == AW'(DIGITS - 1));

  // FSM state register: scan state, digit index and dwell counter.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: one BLANK, one LATCH, then DIV SHOW cycles per digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_BLANK: state_d = ST_LATCH;
      ST_LATCH: begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end
      ST_SHOW: begin
        if (last_dwell) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = last_idx ? '0 : idx_q + AW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: the panel is dark except while the current digit is shown.
  always_comb begin
    an_o = '0;
    if (state_q == ST_SHOW) an_o[idx_q] = 1'b1;
  end

  // Sticky error next state: a fresh parity error in LATCH beats a clear.
  always_comb begin
    err_d = err_clr_i ? '0 : err_q;
    if (state_q == ST_LATCH && !valid_in_i) err_d[idx_q] = 1'b1;
  end

  // Datapath: register file, decoder snapshot, captured segments, error flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DIGITS; i++) mem_q[i] <= 6'b000001;
      E_q   <= '0;
      P_q   <= 1'b1;
      seg_q <= '0;
      err_q <= '0;
    end else begin
      if (wr_hit) mem_q[wr_addr_i] <= {wr_E_i, wr_P_i};
      // Snapshot reads the pre-write entry, so a same-cycle write waits a frame.
      if (state_q == ST_BLANK) {E_q, P_q} <= mem_q[idx_q];
      if (state_q == ST_LATCH) seg_q <= valid_in_i ? seg_in_i : 7'b0000000;
      err_q <= err_d;
    end
  end

  assign E_o       = E_q;
  assign P_o       = P_q;
  assign seg_out_o = seg_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIGITS=4, DIV=4. A behavioural Display
// decoder closes the loop between E/P and seg_in/valid_in. The reference
// model derives digit and phase from the cycle count since reset
// (6 cycles per digit, 24 per frame).
module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int PER    = DIV + 2;
  localparam int FRAME  = DIGITS * PER;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [4:0]        wr_E;
  logic              wr_P;
  logic              err_clr;
  logic [4:0]        E;
  logic              P;
  logic [6:0]        seg_in;
  logic              valid_in;
  logic [6:0]        seg_out;
  logic [DIGITS-1:0] an;
  logic [DIGITS-1:0] err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [5:0] mmem [DIGITS];
  logic [4:0] me;
  logic       mp;
  logic [6:0] mseg;
  logic [3:0] merr;
  int         cyc;

  always #5 clk = ~clk;

  display_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_E_i(wr_E), .wr_P_i(wr_P), .err_clr_i(err_clr),
    .E_o(E), .P_o(P), .seg_in_i(seg_in), .valid_in_i(valid_in),
    .seg_out_o(seg_out), .an_o(an), .err_o(err)
  );

  // Display decoder: hex glyphs, a dash-style glyph for codes 16..31.
  function automatic logic [6:0] disp(input logic [4:0] c);
    logic [6:0] s;
    case (c[3:0])
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    if (c[4]) s = 7'h40 | {3'b000, c[3:0]};
    return s;
  endfunction

  always_comb begin
    seg_in   = disp(E);
    valid_in = ^{E, P};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) mmem[i] = 6'b000001;
    me = 5'd0; mp = 1'b1; mseg = 7'd0; merr = 4'd0; cyc = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs seen at the edge.
  task automatic model_edge();
    int ph, dg;
    logic [3:0] nerr;
    ph   = cyc % PER;
    dg   = (cyc / PER) % DIGITS;
    nerr = err_clr ? 4'd0 : merr;
    if (ph == 0) {me, mp} = mmem[dg];
    else if (ph == 1) begin
      if (^{me, mp}) mseg = disp(me);
      else begin
        mseg     = 7'd0;
        nerr[dg] = 1'b1;
      end
    end
    merr = nerr;
    if (wr_en) mmem[wr_addr] = {wr_E, wr_P};
    cyc++;
  endtask

  function automatic logic [3:0] exp_an();
    if ((cyc % PER) >= 2) return 4'b0001 << ((cyc / PER) % DIGITS);
    return 4'b0000;
  endfunction

  // Advance one clock; compare every output; drop single-cycle pulses.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    chk("an", an, exp_an());
    chk("seg_out", seg_out, mseg);
    chk("err", err, merr);
    chk("E", E, me);
    chk("P", P, mp);
    wr_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  // Step at least once, then until the frame position equals t (bounded).
  task automatic run_to(input int t);
    int n;
    n = 0;
    step();
    while ((cyc % FRAME) != t && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("run_to_reached", cyc % FRAME, t);
  endtask

  task automatic wr(input logic [1:0] a, input logic [4:0] e, input logic p);
    wr_en = 1'b1; wr_addr = a; wr_E = e; wr_P = p;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_E = '0; wr_P = 1'b0; err_clr = 1'b0;
    model_reset();

    // Reset held for two cycles.
    step();
    step();
    chk("rst_seg", seg_out, 7'd0);
    chk("rst_an", an, 4'd0);
    chk("rst_err", err, 4'd0);
    chk("rst_E", E, 5'd0);
    chk("rst_P", P, 1'b1);
    rst_n = 1'b1;

    // Cycle 0: valid write to digit 1; cycle 1: parity-bad write to digit 2.
    wr(2'd1, 5'b00010, 1'b0);
    step();
    wr(2'd2, 5'b00001, 1'b1);
    step();
    chk("an_cyc2", an, 4'b0001);
    run_to(7);
    chk("d1_latch_E", E, 5'b00010);
    chk("d1_latch_P", P, 1'b0);
    chk("d1_valid_in", valid_in, 1'b1);
    step();
    chk("an_cyc8", an, 4'b0010);
    chk("d1_seg", seg_out, 7'h5B);
    chk("d1_err", err[1], 1'b0);
    run_to(14);
    chk("d2_an", an, 4'b0100);
    chk("d2_seg_blank", seg_out, 7'd0);
    chk("d2_err", err, 4'b0100);
    run_to(2);
    chk("an_cyc26", an, 4'b0001);

    // Repair digit 2; it lights next frame, flag stays until cleared.
    wr(2'd2, 5'b00001, 1'b0);
    run_to(14);
    chk("d2_seg_nonzero", seg_out != 7'd0, 1'b1);
    chk("d2_err_sticky", err, 4'b0100);
    err_clr = 1'b1;
    step();
    chk("err_cleared", err, 4'd0);

    // Error beats a clear issued in the same LATCH cycle.
    wr(2'd3, 5'b10101, 1'b1);
    run_to(19);
    err_clr = 1'b1;
    step();
    chk("err_wins", err, 4'b1000);

    // Write during digit 0's BLANK: old snapshot now, new one next frame.
    run_to(0);
    wr(2'd0, 5'b00010, 1'b0);
    step();
    chk("snap_old_E", E, 5'd0);
    chk("snap_old_P", P, 1'b1);
    run_to(1);
    chk("snap_new_E", E, 5'b00010);
    chk("snap_new_P", P, 1'b0);

    // Reset for one cycle during digit 2's SHOW.
    run_to(14);
    rst_n = 1'b0;
    step();
    chk("mid_rst_an", an, 4'd0);
    chk("mid_rst_seg", seg_out, 7'd0);
    chk("mid_rst_err", err, 4'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("mid_rst_an_back", an, 4'b0001);
    // Every entry must read back {0,1} over the next frame.
    for (int i = 0; i < FRAME; i++) step();

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_E    = 5'($urandom_range(0, 31));
      wr_P    = 1'($urandom_range(0, 1));
      err_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
